// File: rtl/pcie_perst_sequencer.sv
// PERST#/refclk power-up sequencer for one PCIe endpoint slot, with timed recovery from link loss.
// Build option PCIE_PERST_SEQ_AUTO_RETRY_EN enables automatic retries; without it every retry decision goes to FAIL.
//
// state    | meaning
// OFF      | slot disabled or unpowered, everything held off
// PWR_WAIT | qualifying pwr_good
// CLK_WAIT | refclk on, qualifying refclk_locked, PERST# asserted
// TRAIN    | PERST# released, waiting for link_up
// UP       | link up
// HOLD     | PERST# re-asserted for a minimum time before requalifying refclk
// FAIL     | retries exhausted, waiting for software reset or abort
module pcie_perst_sequencer #(
  parameter int T_PWR_CYC          = 1000,
  parameter int T_CLK_CYC          = 25000,
  parameter int T_LINK_TIMEOUT_CYC = 250000,
  parameter int T_HOLD_CYC         = 25000,
  parameter int MAX_RETRIES        = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       pwr_good,
  input  logic       refclk_locked,
  input  logic       link_up,
  input  logic       sw_reset_req,
  output logic       perst_n,
  output logic       refclk_oe,
  output logic       link_ready,
  output logic       fail,
  output logic [2:0] state,
  output logic [3:0] retry_count
);

  localparam int T_MAX_A = (T_PWR_CYC > T_CLK_CYC) ? T_PWR_CYC : T_CLK_CYC;
  localparam int T_MAX_B = (T_LINK_TIMEOUT_CYC > T_HOLD_CYC) ? T_LINK_TIMEOUT_CYC : T_HOLD_CYC;
  localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int CW      = $clog2(T_MAX + 1);

  // Terminal counts: the counter holds cycles already completed in the state.
  localparam logic [CW-1:0] PWR_LAST  = CW'(T_PWR_CYC - 1);
  localparam logic [CW-1:0] CLK_LAST  = CW'(T_CLK_CYC - 1);
  localparam logic [CW-1:0] LINK_LAST = CW'(T_LINK_TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(T_HOLD_CYC - 1);
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRIES);

`ifdef PCIE_PERST_SEQ_AUTO_RETRY_EN
  localparam bit AUTO_RETRY = 1'b1;
`else
  localparam bit AUTO_RETRY = 1'b0;
`endif

  localparam logic [2:0] S_OFF      = 3'd0;
  localparam logic [2:0] S_PWR_WAIT = 3'd1;
  localparam logic [2:0] S_CLK_WAIT = 3'd2;
  localparam logic [2:0] S_TRAIN    = 3'd3;
  localparam logic [2:0] S_UP       = 3'd4;
  localparam logic [2:0] S_HOLD     = 3'd5;
  localparam logic [2:0] S_FAIL     = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    retry_q, retry_d;
  logic          retry_ok;
  logic [2:0]    retry_state;
  logic [3:0]    retry_next;
  logic          perst_d, oe_d, ready_d, fail_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_OFF;
      cnt_q      <= '0;
      retry_q    <= '0;
      perst_n    <= 1'b0;
      refclk_oe  <= 1'b0;
      link_ready <= 1'b0;
      fail       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      perst_n    <= perst_d;
      refclk_oe  <= oe_d;
      link_ready <= ready_d;
      fail       <= fail_d;
    end
  end

  always_comb begin
    retry_ok    = AUTO_RETRY && (retry_q < RETRY_MAX);
    retry_state = retry_ok ? S_HOLD : S_FAIL;
    retry_next  = (retry_ok && retry_q != 4'hF) ? retry_q + 4'd1 : retry_q;

    state_d = state_q;
    retry_d = retry_q;
    case (state_q)
      S_OFF:      if (enable && pwr_good) state_d = S_PWR_WAIT;
      S_PWR_WAIT: if (cnt_q == PWR_LAST) state_d = S_CLK_WAIT;
      S_CLK_WAIT: begin
        if (sw_reset_req)                               state_d = S_HOLD;
        else if (refclk_locked && cnt_q == CLK_LAST)    state_d = S_TRAIN;
      end
      S_TRAIN: begin
        if (sw_reset_req)             state_d = S_HOLD;
        else if (link_up)             state_d = S_UP;
        else if (cnt_q == LINK_LAST) begin
          state_d = retry_state;
          retry_d = retry_next;
        end
      end
      S_UP: begin
        if (sw_reset_req)  state_d = S_HOLD;
        else if (!link_up) begin
          state_d = retry_state;
          retry_d = retry_next;
        end
      end
      S_HOLD:     if (cnt_q == HOLD_LAST) state_d = S_CLK_WAIT;
      S_FAIL: begin
        if (sw_reset_req) begin
          state_d = S_HOLD;
          retry_d = '0;
        end
      end
      default:    state_d = S_OFF;
    endcase

    // Loss of enable or power overrides everything, including a pending sw reset.
    if (state_q != S_OFF && (!enable || !pwr_good)) begin
      state_d = S_OFF;
      retry_d = '0;
    end
    if (state_d == S_UP) retry_d = '0;

    cnt_d = '0;
    if (state_d == state_q) begin
      case (state_q)
        S_PWR_WAIT, S_TRAIN, S_HOLD: cnt_d = cnt_q + CW'(1);
        S_CLK_WAIT:                  cnt_d = refclk_locked ? cnt_q + CW'(1) : '0;
        default:                     cnt_d = '0;
      endcase
    end
  end

  always_comb begin
    perst_d = (state_d == S_TRAIN) || (state_d == S_UP);
    oe_d    = (state_d == S_CLK_WAIT) || (state_d == S_TRAIN) ||
              (state_d == S_UP) || (state_d == S_HOLD);
    ready_d = (state_d == S_UP);
    fail_d  = (state_d == S_FAIL);
  end

  assign state       = state_q;
  assign retry_count = retry_q;

endmodule

// File: tb/tb_pcie_perst_sequencer.sv
// Scoreboard bench for pcie_perst_sequencer: stimulus queues expected state transitions,
// a negedge monitor pops one entry each time the DUT outputs change.
module tb_pcie_perst_sequencer;

  localparam int T_PWR  = 8;
  localparam int T_CLK  = 16;
  localparam int T_LINK = 64;
  localparam int T_HOLD = 10;
  localparam int MAXR   = 2;

  localparam int OFF = 0, PWR = 1, CLKW = 2, TRAIN = 3, UP = 4, HOLD = 5, FAILS = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b0, pwr_good = 1'b0, refclk_locked = 1'b0;
  logic       link_up = 1'b0, sw_reset_req = 1'b0;
  logic       perst_n, refclk_oe, link_ready, fail;
  logic [2:0] state;
  logic [3:0] retry_count;

  pcie_perst_sequencer #(
    .T_PWR_CYC(T_PWR), .T_CLK_CYC(T_CLK), .T_LINK_TIMEOUT_CYC(T_LINK),
    .T_HOLD_CYC(T_HOLD), .MAX_RETRIES(MAXR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pwr_good(pwr_good),
    .refclk_locked(refclk_locked), .link_up(link_up), .sw_reset_req(sw_reset_req),
    .perst_n(perst_n), .refclk_oe(refclk_oe), .link_ready(link_ready), .fail(fail),
    .state(state), .retry_count(retry_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cy;
    logic [2:0] st;
    logic [3:0] rc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int cy, input int st, input int rc);
    exp_t e;
    e.cy = cy;
    e.st = 3'(st);
    e.rc = 4'(rc);
    q.push_back(e);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // {perst_n, refclk_oe, link_ready, fail} for a given state
  function automatic logic [3:0] exp_outs(input logic [2:0] st);
    logic p, o, r, f;
    p = (st == 3'(TRAIN)) || (st == 3'(UP));
    o = (st >= 3'(CLKW)) && (st <= 3'(HOLD));
    r = (st == 3'(UP));
    f = (st == 3'(FAILS));
    return {p, o, r, f};
  endfunction

  logic [11:0] snap, prev = 12'd0;
  exp_t        e_mon;

  always @(negedge clk) begin
    snap = {state, perst_n, refclk_oe, link_ready, fail, retry_count};
    if (mon_en && snap !== prev) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_change: got state=%0d retry=%0d at cycle %0d, expected no change",
                 state, retry_count, cyc);
      end else begin
        e_mon = q.pop_front();
        check("event_cycle", cyc, e_mon.cy);
        check("event_state", int'(state), int'(e_mon.st));
        check("event_outputs", int'({perst_n, refclk_oe, link_ready, fail}), int'(exp_outs(e_mon.st)));
        check("event_retry", int'(retry_count), int'(e_mon.rc));
      end
    end
    prev = snap;
  end

  // From HOLD entered at cycle h: requalify refclk, train, raise link_up, reach UP.
  task automatic recover(input int h, input int r);
    link_up = 1'b0;
    push(h + T_HOLD, CLKW, r);
    push(h + T_HOLD + T_CLK, TRAIN, r);
    push(h + 30, UP, 0);
    wait_cyc(h + 3);
    sw_reset_req = 1'b1;          // ignored in HOLD
    @(negedge clk);
    sw_reset_req = 1'b0;
    wait_cyc(h + 29);
    link_up = 1'b1;
    wait_cyc(h + 31);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, f;
    #1 rst_n = 1'b0;
    #3;
    check("reset_state", int'(state), OFF);
    check("reset_perst_n", int'(perst_n), 0);
    check("reset_refclk_oe", int'(refclk_oe), 0);
    check("reset_link_ready", int'(link_ready), 0);
    check("reset_fail", int'(fail), 0);
    check("reset_retry", int'(retry_count), 0);
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // cold boot
    c = cyc;
    enable = 1'b1; pwr_good = 1'b1; refclk_locked = 1'b1;
    push(c + 1, PWR, 0);
    push(c + 9, CLKW, 0);
    push(c + 25, TRAIN, 0);
    push(c + 45, UP, 0);
    wait_cyc(c + 44);
    link_up = 1'b1;
    wait_cyc(c + 46);

    // sw reset from UP, then a one-cycle lock glitch at count 10
    c = cyc;
    sw_reset_req = 1'b1;
    push(c + 1, HOLD, 0);
    push(c + 11, CLKW, 0);
    push(c + 38, TRAIN, 0);
    push(c + 39, UP, 0);
    @(negedge clk);
    sw_reset_req = 1'b0;
    wait_cyc(c + 21);
    refclk_locked = 1'b0;
    wait_cyc(c + 22);
    refclk_locked = 1'b1;
    wait_cyc(c + 40);

    // sw reset wins over simultaneous link loss; then training timeouts
    c = cyc;
    sw_reset_req = 1'b1;
    link_up = 1'b0;
    push(c + 1, HOLD, 0);
    push(c + 11, CLKW, 0);
    push(c + 27, TRAIN, 0);
`ifdef PCIE_PERST_SEQ_AUTO_RETRY_EN
    push(c + 91, HOLD, 1);
    push(c + 101, CLKW, 1);
    push(c + 117, TRAIN, 1);
    push(c + 181, HOLD, 2);
    push(c + 191, CLKW, 2);
    push(c + 207, TRAIN, 2);
    push(c + 271, FAILS, 2);
    f = c + 271;
`else
    push(c + 91, FAILS, 0);
    f = c + 91;
`endif
    @(negedge clk);
    sw_reset_req = 1'b0;
    wait_cyc(f + 3);
    c = cyc;
    sw_reset_req = 1'b1;
    push(c + 1, HOLD, 0);
    @(negedge clk);
    sw_reset_req = 1'b0;
    recover(c + 1, 0);

    // link loss in UP
    c = cyc;
    link_up = 1'b0;
`ifdef PCIE_PERST_SEQ_AUTO_RETRY_EN
    push(c + 1, HOLD, 1);
    @(negedge clk);
    recover(c + 1, 1);
`else
    push(c + 1, FAILS, 0);
    wait_cyc(c + 3);
    c = cyc;
    sw_reset_req = 1'b1;
    push(c + 1, HOLD, 0);
    @(negedge clk);
    sw_reset_req = 1'b0;
    recover(c + 1, 0);
`endif

    // pwr_good abort during TRAIN
    c = cyc;
    sw_reset_req = 1'b1;
    link_up = 1'b0;
    push(c + 1, HOLD, 0);
    push(c + 11, CLKW, 0);
    push(c + 27, TRAIN, 0);
    @(negedge clk);
    sw_reset_req = 1'b0;
    wait_cyc(c + 30);
    pwr_good = 1'b0;
    push(c + 31, OFF, 0);
    wait_cyc(c + 34);

    // reboot straight to UP, then async reset mid-cycle
    c = cyc;
    pwr_good = 1'b1;
    link_up = 1'b1;
    push(c + 1, PWR, 0);
    push(c + 9, CLKW, 0);
    push(c + 25, TRAIN, 0);
    push(c + 26, UP, 0);
    wait_cyc(c + 28);
    push(c + 29, OFF, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_perst_n", int'(perst_n), 0);
    check("async_refclk_oe", int'(refclk_oe), 0);
    check("async_state", int'(state), OFF);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    check("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pcie_perst_sequencer.md
# pcie_perst_sequencer

Controls power-up and reset for one 8-lane PCIe endpoint slot. It sequences slot power-good, reference-clock enable, PERST# release and link-training supervision. It sits between board power/clock monitors and the root-to-endpoint PCIe bundle, and drives that bundle's `perst_n` and reference-clock output enable. Link loss and training timeouts are recovered by a timed PERST# re-assertion; persistent failure is reported to software.

## Interface
- `T_PWR_CYC`, 1000: consecutive `pwr_good` cycles required before the reference clock is enabled (≥1).
- `T_CLK_CYC`, 25000: consecutive `refclk_locked` cycles before PERST# release; 100 µs at 250 MHz (≥1).
- `T_LINK_TIMEOUT_CYC`, 250000: cycles allowed in training for `link_up` to assert (≥1).
- `T_HOLD_CYC`, 25000: minimum PERST# assertion time on a retry or software reset (≥1).
- `MAX_RETRIES`, 3: automatic retries before FAIL (0..15).
- `clk`, in, 1: single system clock; every register is on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `enable`, in, 1: slot enable from software; low forces OFF.
- `pwr_good`, in, 1: slot power good; already synchronised to `clk`.
- `refclk_locked`, in, 1: reference-clock buffer lock/stable indication; synchronised.
- `link_up`, in, 1: data-link-layer up, from the PCIe core; synchronised.
- `sw_reset_req`, in, 1: one-cycle pulse requesting a hot reset.
- `perst_n`, out, 1: PERST# to the endpoint; low = reset asserted.
- `refclk_oe`, out, 1: reference-clock output enable.
- `link_ready`, out, 1: high only in UP.
- `fail`, out, 1: high only in FAIL.
- `state`, out, 3: current state encoding.
- `retry_count`, out, 4: automatic retries consumed since the last UP or OFF.

## Operation
- State encodings: OFF=0, PWR_WAIT=1, CLK_WAIT=2, TRAIN=3, UP=4, HOLD=5, FAIL=6. Codes 7 and above are unreachable; if one occurs, the next state is OFF.
- Moore machine. All outputs are registered and decoded from the state register:
  - `refclk_oe`=1 in CLK_WAIT, TRAIN, UP and HOLD.
  - `perst_n`=1 in TRAIN and UP only.
- One shared cycle counter, sized to the largest T_* parameter. It clears on every state change.
- Global abort, highest priority: `enable`=0 or `pwr_good`=0 in any state other than OFF → OFF. `retry_count` clears.
- OFF → PWR_WAIT when `enable`=1 and `pwr_good`=1.
- PWR_WAIT → CLK_WAIT after `T_PWR_CYC` cycles.
- CLK_WAIT:
  - The counter advances only while `refclk_locked`=1. It clears on any cycle with `refclk_locked`=0.
  - When the count reaches `T_CLK_CYC` → TRAIN.
- TRAIN:
  - `link_up`=1 → UP.
  - Counter reaches `T_LINK_TIMEOUT_CYC` → retry decision.
- UP:
  - `retry_count` clears on entry.
  - `link_up`=0 → retry decision.
- Retry decision:
  - If `retry_count` < `MAX_RETRIES`: increment `retry_count` and → HOLD.
  - Otherwise → FAIL.
- HOLD → CLK_WAIT after `T_HOLD_CYC` cycles. `refclk_locked` is re-qualified in CLK_WAIT.
- `sw_reset_req` in CLK_WAIT, TRAIN or UP → HOLD without changing `retry_count`.
- `sw_reset_req` in FAIL → HOLD and clears `retry_count`. FAIL is otherwise exited only by the global abort.
- `sw_reset_req` is ignored in OFF, PWR_WAIT and HOLD.
- Simultaneous events, priority order: abort > `sw_reset_req` > `link_up`/timeout. If `link_up` rises on the same cycle the timeout expires, `link_up` wins and the next state is UP.
- `retry_count` saturates at 15.

## Timing
- Reset values: `state`=OFF, `perst_n`=0, `refclk_oe`=0, `link_ready`=0, `fail`=0, `retry_count`=0, counter=0.
- Latency is one clock from the sampled input condition to the new state and its outputs.
- `refclk_oe` rises `T_PWR_CYC`+1 cycles after `enable`&`pwr_good` is first sampled high.
- `perst_n` rises on the edge where the `T_CLK_CYC`-th consecutive `refclk_locked`=1 sample completes.
- PERST# low time on retry ≥ `T_HOLD_CYC`+`T_CLK_CYC` cycles.
- `rst_n` asserted mid-sequence drops `perst_n` and `refclk_oe` asynchronously, within the same cycle.

## Configuration
- `PCIE_PERST_SEQ_AUTO_RETRY_EN` defined: retry decisions behave as described above.
- Not defined: every retry decision goes directly to FAIL, and `retry_count` stays 0. `MAX_RETRIES` is ignored; `sw_reset_req` recovery is unchanged.

## Test plan
Parameters for all scenarios: `T_PWR_CYC`=8, `T_CLK_CYC`=16, `T_LINK_TIMEOUT_CYC`=64, `T_HOLD_CYC`=10, `MAX_RETRIES`=2, macro defined.
- Cold boot: `enable`, `pwr_good` and `refclk_locked` held high → `refclk_oe` rises at cycle 9; `perst_n` rises 16 cycles later; `link_up` at +20 → `link_ready`=1, `state`=4.
- Lock glitch: `refclk_locked` drops for 1 cycle at count 10 in CLK_WAIT → counter restarts; `perst_n` rises 16 cycles after relock.
- Timeout retries: `link_up` held low → HOLD twice (`retry_count` 1, 2), each with `perst_n` low ≥26 cycles; third timeout → `fail`=1, `state`=6. Then `sw_reset_req` → HOLD with `retry_count`=0.
- Link loss: in UP, `link_up` falls → `link_ready`=0, `perst_n`=0 next cycle, `retry_count`=1; relink → UP with `retry_count`=0.
- Abort: `pwr_good` falls during TRAIN → OFF next cycle, all outputs 0. Separately, `rst_n` asserted in UP → `perst_n`=0 immediately.
- Macro undefined: first training timeout → FAIL directly, `retry_count`=0.
